// File: rtl/first_layer_seq.sv
// Frame sequencer for the first convolution layer: raster-reads the three channel
// memories into the layer, counts its output beats and watches for a stalled layer.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing one pixel read per non-held cycle
// DRAIN | reads done, waiting for the remaining output beats
// DONE  | one-cycle done pulse
module first_layer_seq #(
   parameter int DATA_WIDTH = 32,
   parameter int IMG_W      = 299,
   parameter int IMG_H      = 299,
   parameter int OUT_W      = 147,
   parameter int OUT_H      = 147,
   parameter int ADDR_WIDTH = 17,
   parameter int TIMEOUT    = 4096
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  hold,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rd_data_1,
   input  logic [DATA_WIDTH-1:0] mem_rd_data_2,
   input  logic [DATA_WIDTH-1:0] mem_rd_data_3,
   output logic [DATA_WIDTH-1:0] pxl_in_1,
   output logic [DATA_WIDTH-1:0] pxl_in_2,
   output logic [DATA_WIDTH-1:0] pxl_in_3,
   output logic                  valid_in_1,
   output logic                  valid_in_2,
   output logic                  valid_in_3,
   input  logic [31:0]           valid_out_vec
);

   localparam int N_PIX = IMG_W * IMG_H;
   localparam int N_OUT = OUT_W * OUT_H;
   localparam int COL_W = $clog2(IMG_W + 1);
   localparam int ROW_W = $clog2(IMG_H + 1);
   localparam int CNT_W = $clog2(N_OUT + 1);
   localparam int WD_W  = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t             state, state_nxt;
   logic [COL_W-1:0]   col;
   logic [ROW_W-1:0]   row;
   logic [CNT_W-1:0]   out_cnt;
   logic [WD_W-1:0]    wdog;
   logic               valid_q;
   logic               start_acc;
   logic               beat;
   logic               mismatch;
   logic               out_full;
   logic               last_addr;
   logic               wd_expire;

   assign pxl_in_1   = mem_rd_data_1;
   assign pxl_in_2   = mem_rd_data_2;
   assign pxl_in_3   = mem_rd_data_3;
   assign valid_in_1 = valid_q;
   assign valid_in_2 = valid_q;
   assign valid_in_3 = valid_q;

   assign busy      = (state == S_FETCH) || (state == S_DRAIN);
   assign done      = (state == S_DONE);
   assign mem_rd_en = (state == S_FETCH) && !hold;
   assign start_acc = (state == S_IDLE) && start;
   assign beat      = busy && valid_out_vec[0];
   // The 32 channel valids must move together; any split pattern is a layer fault.
   assign mismatch  = (valid_out_vec != '0) && (valid_out_vec != '1);
   assign out_full  = (out_cnt == CNT_W'(N_OUT));
   assign last_addr = (mem_addr == ADDR_WIDTH'(N_PIX - 1));
   assign wd_expire = (state == S_DRAIN) && !out_full && !beat
                      && (wdog == WD_W'(TIMEOUT - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_FETCH;
         S_FETCH: if (mem_rd_en && last_addr) state_nxt = S_DRAIN;
         S_DRAIN: if (out_full || wd_expire) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         valid_q  <= 1'b0;
         mem_addr <= '0;
         col      <= '0;
         row      <= '0;
         out_cnt  <= '0;
         wdog     <= '0;
         err      <= 1'b0;
      end else begin
         state   <= state_nxt;
         valid_q <= mem_rd_en;

         if (start_acc) begin
            mem_addr <= '0;
            col      <= '0;
            row      <= '0;
            out_cnt  <= '0;
         end else begin
            if (mem_rd_en) begin
               mem_addr <= mem_addr + 1'b1;
               if (col == COL_W'(IMG_W - 1)) begin
                  col <= '0;
                  row <= row + 1'b1;
               end else begin
                  col <= col + 1'b1;
               end
            end
            if (beat && !out_full) out_cnt <= out_cnt + 1'b1;
         end

         // Watchdog only runs in DRAIN, so it is already zero on DRAIN entry.
         if (state != S_DRAIN || beat) wdog <= '0;
         else                          wdog <= wdog + 1'b1;

         if (mismatch || (beat && out_full) || wd_expire) err <= 1'b1;
         else if (start_acc)                               err <= 1'b0;
      end
   end

endmodule
